// File: rtl/enemy_track_filter.sv
// Per-enemy position/velocity tracker. Dead-reckons cloaked enemies from their
// last velocity; every output is registered and advances only on frame_valid.
module enemy_track_filter #(
  parameter int N_ENEMY   = 3,
  parameter int VEL_MAX   = 8,
  parameter int ARENA_LIM = 64,
  parameter int MAX_COAST = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_valid,
  input  logic [N_ENEMY*8-1:0]   enemy_x_p,
  input  logic [N_ENEMY*8-1:0]   enemy_y_p,
  input  logic [N_ENEMY-1:0]     enemy_cloaked,
  input  logic [N_ENEMY-1:0]     enemy_destroyed,
  output logic [N_ENEMY*8-1:0]   trk_x,
  output logic [N_ENEMY*8-1:0]   trk_y,
  output logic [N_ENEMY*8-1:0]   trk_vx,
  output logic [N_ENEMY*8-1:0]   trk_vy,
  output logic [N_ENEMY-1:0]     trk_valid,
  output logic [N_ENEMY*3-1:0]   trk_state,
  output logic [N_ENEMY*4-1:0]   coast_age
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FIRST = 3'd1,
    S_TRACK = 3'd2,
    S_COAST = 3'd3,
    S_LOST  = 3'd4,
    S_DEAD  = 3'd5
  } state_t;

  localparam logic signed [8:0] V_HI    = 9'(VEL_MAX);
  localparam logic signed [8:0] V_LO    = 9'(-VEL_MAX);
  localparam logic signed [8:0] P_HI    = 9'(ARENA_LIM);
  localparam logic signed [8:0] P_LO    = 9'(-ARENA_LIM);
  localparam logic [3:0]        AGE_MAX = 4'(MAX_COAST);

  function automatic logic signed [8:0] ext(input logic signed [7:0] a);
    return {a[7], a};
  endfunction

  // All arithmetic is done 9-bit so a clamp always happens before any 8-bit wrap.
  function automatic logic signed [7:0] sat(input logic signed [8:0] v,
                                            input logic signed [8:0] hi,
                                            input logic signed [8:0] lo);
    logic signed [8:0] r;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r[7:0];
  endfunction

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    state_t            state, state_n;
    logic signed [7:0] x, y, vx, vy, x_n, y_n, vx_n, vy_n;
    logic signed [7:0] mx, my;
    logic signed [8:0] dx, dy, px, py;
    logic [3:0]        age, age_n;
    logic              valid, valid_n, cl;

    assign mx = enemy_x_p[i*8 +: 8];
    assign my = enemy_y_p[i*8 +: 8];
    assign cl = enemy_cloaked[i];

    always_comb begin
      state_n = state;
      x_n     = x;
      y_n     = y;
      vx_n    = vx;
      vy_n    = vy;
      age_n   = age;
      dx      = ext(mx) - ext(x);
      dy      = ext(my) - ext(y);
      px      = ext(x) + ext(vx);
      py      = ext(y) + ext(vy);
      if (enemy_destroyed[i]) begin
        state_n = S_DEAD;
        vx_n    = '0;
        vy_n    = '0;
        age_n   = '0;
      end else begin
        case (state)
          S_INIT, S_LOST: begin
            if (!cl) begin
              state_n = S_FIRST;
              x_n     = mx;
              y_n     = my;
              vx_n    = '0;
              vy_n    = '0;
            end
          end
          S_FIRST, S_TRACK: begin
            if (!cl) begin
              state_n = S_TRACK;
              vx_n    = sat(dx, V_HI, V_LO);
              vy_n    = sat(dy, V_HI, V_LO);
              x_n     = mx;
              y_n     = my;
            end else begin
              state_n = S_COAST;
              age_n   = 4'd1;
              x_n     = sat(px, P_HI, P_LO);
              y_n     = sat(py, P_HI, P_LO);
            end
          end
          S_COAST: begin
            // Reacquiring keeps the coasted velocity; FIRST re-measures it next frame.
            if (!cl) begin
              state_n = S_FIRST;
              x_n     = mx;
              y_n     = my;
              age_n   = '0;
            end else if (age < AGE_MAX) begin
              age_n   = age + 4'd1;
              x_n     = sat(px, P_HI, P_LO);
              y_n     = sat(py, P_HI, P_LO);
            end else begin
              state_n = S_LOST;
              vx_n    = '0;
              vy_n    = '0;
              age_n   = '0;
            end
          end
          default: begin
          end
        endcase
      end
      valid_n = (state_n == S_FIRST) || (state_n == S_TRACK) || (state_n == S_COAST);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= S_INIT;
        x     <= '0;
        y     <= '0;
        vx    <= '0;
        vy    <= '0;
        age   <= '0;
        valid <= 1'b0;
      end else if (frame_valid) begin
        state <= state_n;
        x     <= x_n;
        y     <= y_n;
        vx    <= vx_n;
        vy    <= vy_n;
        age   <= age_n;
        valid <= valid_n;
      end
    end

    assign trk_x[i*8 +: 8]     = x;
    assign trk_y[i*8 +: 8]     = y;
    assign trk_vx[i*8 +: 8]    = vx;
    assign trk_vy[i*8 +: 8]    = vy;
    assign trk_valid[i]        = valid;
    assign trk_state[i*3 +: 3] = state;
    assign coast_age[i*4 +: 4] = age;
  end

endmodule

// File: tb/tb_enemy_track_filter.sv
// Bench for enemy_track_filter: directed tracking scenarios plus randomized
// frames compared against an integer reference model of the tracker.
module tb_enemy_track_filter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset, frame_valid;
  logic [N*8-1:0] enemy_x_p, enemy_y_p;
  logic [N-1:0]   enemy_cloaked, enemy_destroyed;
  logic [N*8-1:0] trk_x, trk_y, trk_vx, trk_vy;
  logic [N-1:0]   trk_valid;
  logic [N*3-1:0] trk_state;
  logic [N*4-1:0] coast_age;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_age[N];

  enemy_track_filter dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid),
    .enemy_x_p(enemy_x_p), .enemy_y_p(enemy_y_p),
    .enemy_cloaked(enemy_cloaked), .enemy_destroyed(enemy_destroyed),
    .trk_x(trk_x), .trk_y(trk_y), .trk_vx(trk_vx), .trk_vy(trk_vy),
    .trk_valid(trk_valid), .trk_state(trk_state), .coast_age(coast_age)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : (v < -lim) ? -lim : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_x[i] = 0; m_y[i] = 0;
      m_vx[i] = 0; m_vy[i] = 0; m_age[i] = 0;
    end
  endtask

  // Reference tracker: states 0 INIT,1 FIRST,2 TRACK,3 COAST,4 LOST,5 DEAD.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int mx, my;
      mx = int'($signed(enemy_x_p[i*8 +: 8]));
      my = int'($signed(enemy_y_p[i*8 +: 8]));
      if (enemy_destroyed[i]) begin
        m_state[i] = 5; m_vx[i] = 0; m_vy[i] = 0; m_age[i] = 0;
      end else if (m_state[i] == 5) begin
      end else if (!enemy_cloaked[i]) begin
        if (m_state[i] == 1 || m_state[i] == 2) begin
          m_vx[i] = clampi(mx - m_x[i], 8);
          m_vy[i] = clampi(my - m_y[i], 8);
          m_state[i] = 2;
        end else begin
          if (m_state[i] != 3) begin m_vx[i] = 0; m_vy[i] = 0; end
          m_state[i] = 1;
          m_age[i] = 0;
        end
        m_x[i] = mx; m_y[i] = my;
      end else if (m_state[i] == 1 || m_state[i] == 2 || (m_state[i] == 3 && m_age[i] < 6)) begin
        m_x[i] = clampi(m_x[i] + m_vx[i], 64);
        m_y[i] = clampi(m_y[i] + m_vy[i], 64);
        m_age[i] = m_age[i] + 1;
        m_state[i] = 3;
      end else if (m_state[i] == 3) begin
        m_state[i] = 4; m_vx[i] = 0; m_vy[i] = 0; m_age[i] = 0;
      end
    end
  endtask

  function automatic logic [N*8-1:0] pk8(input int a[N]);
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  function automatic logic [N*4-1:0] pk4(input int a[N]);
    logic [N*4-1:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(a[i]);
    return r;
  endfunction

  function automatic logic [N*3-1:0] pk3(input int a[N]);
    logic [N*3-1:0] r;
    for (int i = 0; i < N; i++) r[i*3 +: 3] = 3'(a[i]);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_state[i] >= 1 && m_state[i] <= 3);
    return r;
  endfunction

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic do_frame();
    frame_valid = 1'b1;
    model_step();
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic set_e0(input int x, input int y);
    enemy_x_p[7:0] = 8'(x);
    enemy_y_p[7:0] = 8'(y);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_valid = 1'b1;
    enemy_x_p = 24'h123456; enemy_y_p = 24'h654321;
    enemy_cloaked = '0; enemy_destroyed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0; frame_valid = 1'b0;
    model_reset();
    n_checks++;
    if ({trk_x, trk_y, trk_vx, trk_vy} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_pos_vel got %h expected 0", {trk_x, trk_y, trk_vx, trk_vy});
    end
    n_checks++;
    if ({trk_valid, trk_state, coast_age} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_state got %h expected 0", {trk_valid, trk_state, coast_age});
    end
  endtask

  task automatic test_track();
    enemy_cloaked = 3'b110; enemy_destroyed = '0;
    enemy_x_p = '0; enemy_y_p = '0;
    set_e0(10, 0); do_frame();
    set_e0(13, 0); do_frame();
    set_e0(17, 0); do_frame();
    n_checks++;
    if (trk_x[7:0] !== 8'd17 || trk_vx[7:0] !== 8'd4) begin
      n_fail++; $display("[TB] FAIL track_x_vx got x=%0d vx=%0d expected x=17 vx=4",
                         $signed(trk_x[7:0]), $signed(trk_vx[7:0]));
    end
    n_checks++;
    if (trk_valid !== 3'b001 || trk_state !== 9'o002) begin
      n_fail++; $display("[TB] FAIL track_state got valid=%b state=%o expected valid=001 state=002",
                         trk_valid, trk_state);
    end
  endtask

  task automatic test_coast();
    set_e0(15, 0); do_frame();
    set_e0(20, 0); do_frame();
    n_checks++;
    if (trk_x[7:0] !== 8'd20 || trk_vx[7:0] !== 8'd5) begin
      n_fail++; $display("[TB] FAIL coast_setup got x=%0d vx=%0d expected x=20 vx=5",
                         $signed(trk_x[7:0]), $signed(trk_vx[7:0]));
    end
    enemy_cloaked = 3'b111;
    set_e0(-99, 77);
    for (int k = 1; k <= 3; k++) begin
      do_frame();
      n_checks++;
      if (trk_x[7:0] !== 8'(20 + 5*k) || coast_age[3:0] !== 4'(k) || trk_state[2:0] !== 3'd3) begin
        n_fail++; $display("[TB] FAIL coast_frame%0d got x=%0d age=%0d state=%0d expected x=%0d age=%0d state=3",
                           k, $signed(trk_x[7:0]), coast_age[3:0], trk_state[2:0], 20 + 5*k, k);
      end
    end
  endtask

  task automatic test_lost();
    repeat (4) do_frame();
    n_checks++;
    if (trk_state[2:0] !== 3'd4 || trk_valid[0] !== 1'b0 || trk_vx[7:0] !== 8'd0 ||
        trk_x[7:0] !== 8'd50 || coast_age[3:0] !== 4'd0) begin
      n_fail++; $display("[TB] FAIL lost got state=%0d valid=%b vx=%0d x=%0d age=%0d expected 4 0 0 50 0",
                         trk_state[2:0], trk_valid[0], $signed(trk_vx[7:0]), $signed(trk_x[7:0]), coast_age[3:0]);
    end
    enemy_cloaked = 3'b110;
    set_e0(-7, 0); do_frame();
    n_checks++;
    if (trk_state[2:0] !== 3'd1 || trk_x[7:0] !== 8'hF9 || trk_valid[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reacquire got state=%0d x=%0d valid=%b expected 1 -7 1",
                         trk_state[2:0], $signed(trk_x[7:0]), trk_valid[0]);
    end
  endtask

  task automatic test_saturation();
    set_e0(52, 0); do_frame();
    set_e0(60, 0); do_frame();
    enemy_cloaked = 3'b111; do_frame();
    n_checks++;
    if (trk_x[7:0] !== 8'd64) begin
      n_fail++; $display("[TB] FAIL pos_clamp got %0d expected 64", $signed(trk_x[7:0]));
    end
    enemy_cloaked = 3'b110;
    set_e0(-100, 0); do_frame();
    set_e0(100, 0);  do_frame();
    n_checks++;
    if (trk_vx[7:0] !== 8'd8 || trk_x[7:0] !== 8'd100) begin
      n_fail++; $display("[TB] FAIL vel_clamp_pos got vx=%0d x=%0d expected 8 100",
                         $signed(trk_vx[7:0]), $signed(trk_x[7:0]));
    end
    set_e0(-100, 0); do_frame();
    n_checks++;
    if (trk_vx[7:0] !== 8'hF8) begin
      n_fail++; $display("[TB] FAIL vel_clamp_neg got %0d expected -8", $signed(trk_vx[7:0]));
    end
  endtask

  task automatic test_destroyed();
    enemy_cloaked = 3'b111; do_frame();
    n_checks++;
    if (trk_x[7:0] !== 8'hC0 || trk_state[2:0] !== 3'd3) begin
      n_fail++; $display("[TB] FAIL neg_clamp got x=%0d state=%0d expected -64 3",
                         $signed(trk_x[7:0]), trk_state[2:0]);
    end
    enemy_destroyed = 3'b001; do_frame();
    n_checks++;
    if (trk_state[2:0] !== 3'd5 || trk_valid[0] !== 1'b0 || trk_vx[7:0] !== 8'd0 ||
        trk_vy[7:0] !== 8'd0 || trk_x[7:0] !== 8'hC0) begin
      n_fail++; $display("[TB] FAIL dead got state=%0d valid=%b vx=%0d vy=%0d x=%0d expected 5 0 0 0 -64",
                         trk_state[2:0], trk_valid[0], $signed(trk_vx[7:0]), $signed(trk_vy[7:0]), $signed(trk_x[7:0]));
    end
    enemy_destroyed = '0;
    enemy_cloaked = 3'b110;
    set_e0(5, 5); do_frame();
    n_checks++;
    if (trk_state[2:0] !== 3'd5 || trk_x[7:0] !== 8'hC0) begin
      n_fail++; $display("[TB] FAIL dead_sticky got state=%0d x=%0d expected 5 -64",
                         trk_state[2:0], $signed(trk_x[7:0]));
    end
  endtask

  task automatic test_hold();
    frame_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      enemy_x_p = 24'($urandom); enemy_y_p = 24'($urandom);
      enemy_cloaked = 3'($urandom); enemy_destroyed = 3'($urandom);
      @(negedge clk);
      n_checks++;
      if (trk_x !== pk8(m_x) || trk_vx !== pk8(m_vx) || trk_state !== pk3(m_state) ||
          coast_age !== pk4(m_age) || trk_valid !== exp_valid()) begin
        n_fail++; $display("[TB] FAIL hold cycle %0d got x=%h vx=%h st=%o expected x=%h vx=%h st=%o",
                           k, trk_x, trk_vx, trk_state, pk8(m_x), pk8(m_vx), pk3(m_state));
      end
    end
  endtask

  task automatic test_reset_in_coast();
    enemy_destroyed = '0;
    enemy_cloaked = 3'b101;
    enemy_x_p[15:8] = 8'd30; enemy_y_p[15:8] = 8'd40; do_frame();
    enemy_x_p[15:8] = 8'd33; enemy_y_p[15:8] = 8'd38; do_frame();
    enemy_cloaked = 3'b111; do_frame();
    n_checks++;
    if (trk_state[5:3] !== 3'd3 || trk_x[15:8] !== 8'd36 || trk_y[15:8] !== 8'd36) begin
      n_fail++; $display("[TB] FAIL coast_e1 got state=%0d x=%0d y=%0d expected 3 36 36",
                         trk_state[5:3], $signed(trk_x[15:8]), $signed(trk_y[15:8]));
    end
    reset = 1'b1; frame_valid = 1'b1; enemy_cloaked = '0;
    @(negedge clk);
    reset = 1'b0; frame_valid = 1'b0;
    model_reset();
    n_checks++;
    if ({trk_x, trk_y, trk_vx, trk_vy, trk_valid, trk_state, coast_age} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_in_coast got state=%o x=%h valid=%b expected all 0",
                         trk_state, trk_x, trk_valid);
    end
  endtask

  task automatic test_random();
    int cloak_pct;
    cloak_pct = 30;
    for (int f = 0; f < 600; f++) begin
      if (f % 60 == 0) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        model_reset();
        cloak_pct = (cloak_pct == 30) ? 85 : 30;
      end
      enemy_x_p = 24'($urandom); enemy_y_p = 24'($urandom);
      for (int i = 0; i < N; i++) begin
        enemy_cloaked[i]   = ($urandom_range(0, 99) < cloak_pct);
        enemy_destroyed[i] = ($urandom_range(0, 99) < 2);
        if ($urandom_range(0, 3) == 0) enemy_x_p[i*8 +: 8] = 8'($urandom_range(0, 30) - 15);
      end
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      else do_frame();
      n_checks++;
      if (trk_x !== pk8(m_x) || trk_y !== pk8(m_y)) begin
        n_fail++; $display("[TB] FAIL rand_pos frame %0d got x=%h y=%h expected x=%h y=%h",
                           f, trk_x, trk_y, pk8(m_x), pk8(m_y));
      end
      n_checks++;
      if (trk_vx !== pk8(m_vx) || trk_vy !== pk8(m_vy)) begin
        n_fail++; $display("[TB] FAIL rand_vel frame %0d got vx=%h vy=%h expected vx=%h vy=%h",
                           f, trk_vx, trk_vy, pk8(m_vx), pk8(m_vy));
      end
      n_checks++;
      if (trk_state !== pk3(m_state) || coast_age !== pk4(m_age) || trk_valid !== exp_valid()) begin
        n_fail++; $display("[TB] FAIL rand_state frame %0d got st=%o age=%h v=%b expected st=%o age=%h v=%b",
                           f, trk_state, coast_age, trk_valid, pk3(m_state), pk4(m_age), exp_valid());
      end
    end
  endtask

  initial begin
    reset = 1'b1; frame_valid = 1'b0;
    enemy_x_p = '0; enemy_y_p = '0; enemy_cloaked = '0; enemy_destroyed = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_track();
    test_coast();
    test_lost();
    test_saturation();
    test_destroyed();
    test_hold();
    test_reset_in_coast();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
